// File: rtl/traffic_light_monitor.sv
// Observer beside the traffic light controller: tracks the green->yellow->red
// sequence, times each phase, models the waiting vehicle queue and drives walkButton.
module traffic_light_monitor #(
    parameter int TIME_W  = 11,
    parameter int COUNT_W = 9
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [1:0]         light,
    input  logic               carArrive,
    input  logic               pedPress,
    output logic               walkButton,
    output logic [COUNT_W-1:0] queueLen,
    output logic [TIME_W-1:0]  greenTime,
    output logic [TIME_W-1:0]  yellowTime,
    output logic [TIME_W-1:0]  redTime,
    output logic [COUNT_W-1:0] cycleCount,
    output logic               seqError,
    output logic               queueOverflow
);

    typedef enum logic [1:0] {S_INIT, S_GREEN, S_YELLOW, S_RED} state_t;

    localparam logic [1:0] L_GREEN  = 2'b10;
    localparam logic [1:0] L_YELLOW = 2'b01;
    localparam logic [1:0] L_RED    = 2'b00;
    localparam logic [1:0] L_BAD    = 2'b11;

    state_t               r_state;
    logic [TIME_W-1:0]    r_phase_cnt;
    logic                 r_ytoggle;
    logic [COUNT_W-1:0]   r_queue;
    logic [TIME_W-1:0]    r_green;
    logic [TIME_W-1:0]    r_yellow;
    logic [TIME_W-1:0]    r_red;
    logic [COUNT_W-1:0]   r_cycle;
    logic                 r_seq_err;
    logic                 r_ovf;
    logic                 r_walk;

    state_t               w_code_state;
    state_t               w_legal_next;
    logic                 w_tracking;
    logic                 w_enter_red;
    logic                 w_enter_yellow;
    logic                 w_depart;

    function automatic logic [TIME_W-1:0] sat_inc(input logic [TIME_W-1:0] v);
        if (v == {TIME_W{1'b1}})
            sat_inc = v;
        else
            sat_inc = v + TIME_W'(1);
    endfunction

    always_comb begin
        w_code_state = S_RED;
        case (light)
            L_GREEN:  w_code_state = S_GREEN;
            L_YELLOW: w_code_state = S_YELLOW;
            L_RED:    w_code_state = S_RED;
            default:  w_code_state = S_INIT;
        endcase
    end

    always_comb begin
        w_legal_next = S_INIT;
        case (r_state)
            S_GREEN:  w_legal_next = S_YELLOW;
            S_YELLOW: w_legal_next = S_RED;
            S_RED:    w_legal_next = S_GREEN;
            default:  w_legal_next = S_INIT;
        endcase
    end

    // INIT ignores 00/01, so red/yellow can only be entered from a tracking state
    assign w_tracking     = (r_state != S_INIT);
    assign w_enter_red    = w_tracking && (r_state != S_RED)    && (light == L_RED);
    assign w_enter_yellow = w_tracking && (r_state != S_YELLOW) && (light == L_YELLOW);
    assign w_depart       = (r_queue != '0) &&
                            ((r_state == S_GREEN) || ((r_state == S_YELLOW) && r_ytoggle));

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_INIT;
            r_phase_cnt <= '0;
            r_ytoggle   <= 1'b0;
            r_queue     <= '0;
            r_green     <= '0;
            r_yellow    <= '0;
            r_red       <= '0;
            r_cycle     <= '0;
            r_seq_err   <= 1'b0;
            r_ovf       <= 1'b0;
            r_walk      <= 1'b0;
        end else begin
            if (light == L_BAD) begin
                r_seq_err   <= 1'b1;
                r_state     <= S_INIT;
                r_phase_cnt <= '0;
            end else if (r_state == S_INIT) begin
                if (light == L_GREEN) begin
                    r_state     <= S_GREEN;
                    r_phase_cnt <= TIME_W'(1);
                end
            end else if (w_code_state == r_state) begin
                r_phase_cnt <= sat_inc(r_phase_cnt);
            end else begin
                r_state     <= w_code_state;
                r_phase_cnt <= TIME_W'(1);
                if (w_code_state == w_legal_next) begin
                    case (r_state)
                        S_GREEN:  r_green  <= r_phase_cnt;
                        S_YELLOW: r_yellow <= r_phase_cnt;
                        S_RED: begin
                            r_red   <= r_phase_cnt;
                            r_cycle <= r_cycle + COUNT_W'(1);
                        end
                        default: ;
                    endcase
                end else begin
                    r_seq_err <= 1'b1;
                end
            end

            if (w_enter_yellow)
                r_ytoggle <= 1'b0;
            else if (r_state == S_YELLOW)
                r_ytoggle <= ~r_ytoggle;

            // simultaneous arrival and departure cancel out
            if (carArrive && !w_depart) begin
                if (r_queue == {COUNT_W{1'b1}})
                    r_ovf <= 1'b1;
                else
                    r_queue <= r_queue + COUNT_W'(1);
            end else if (w_depart && !carArrive) begin
                r_queue <= r_queue - COUNT_W'(1);
            end

            if (w_enter_red)
                r_walk <= 1'b0;
            else if (pedPress && ((r_state == S_GREEN) || (r_state == S_YELLOW)))
                r_walk <= 1'b1;
        end
    end

    assign walkButton    = r_walk;
    assign queueLen      = r_queue;
    assign greenTime     = r_green;
    assign yellowTime    = r_yellow;
    assign redTime       = r_red;
    assign cycleCount    = r_cycle;
    assign seqError      = r_seq_err;
    assign queueOverflow = r_ovf;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed and randomized bench for traffic_light_monitor, checked every cycle
// against a run-length model of the light sequence and queue.
module tb_traffic_light_monitor;

    localparam int TIME_W  = 11;
    localparam int COUNT_W = 9;
    localparam int TMAX    = (1 << TIME_W) - 1;
    localparam int QMAX    = (1 << COUNT_W) - 1;

    logic               clock;
    logic               reset;
    logic [1:0]         light;
    logic               carArrive;
    logic               pedPress;
    logic               walkButton;
    logic [COUNT_W-1:0] queueLen;
    logic [TIME_W-1:0]  greenTime;
    logic [TIME_W-1:0]  yellowTime;
    logic [TIME_W-1:0]  redTime;
    logic [COUNT_W-1:0] cycleCount;
    logic               seqError;
    logic               queueOverflow;

    int total;
    int bad;

    // model: colour index 0=green 1=yellow 2=red, -1 = not yet synchronised
    int m_trk;
    int m_run;
    int m_dur [3];
    int m_cyc;
    int m_q;
    int m_ycnt;
    bit m_err;
    bit m_ovf;
    bit m_walk;

    traffic_light_monitor #(.TIME_W(TIME_W), .COUNT_W(COUNT_W)) dut (
        .clock(clock), .reset(reset), .light(light), .carArrive(carArrive),
        .pedPress(pedPress), .walkButton(walkButton), .queueLen(queueLen),
        .greenTime(greenTime), .yellowTime(yellowTime), .redTime(redTime),
        .cycleCount(cycleCount), .seqError(seqError), .queueOverflow(queueOverflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int colour(input logic [1:0] l);
        case (l)
            2'b10:   colour = 0;
            2'b01:   colour = 1;
            2'b00:   colour = 2;
            default: colour = 3;
        endcase
    endfunction

    task automatic model_reset();
        m_trk = -1; m_run = 0; m_cyc = 0; m_q = 0; m_ycnt = 0;
        m_err = 0; m_ovf = 0; m_walk = 0;
        for (int i = 0; i < 3; i++) m_dur[i] = 0;
    endtask

    task automatic model_step(input logic [1:0] l, input bit car, input bit ped);
        int col;
        int nt;
        bit dep;
        col = colour(l);
        // yellow vehicles leave on the even-numbered yellow cycles
        dep = (m_q > 0) && ((m_trk == 0) || (m_trk == 1 && (m_ycnt % 2) == 1));
        nt  = m_trk;
        if (col == 3) begin
            m_err = 1; nt = -1; m_run = 0;
        end else if (m_trk == -1) begin
            if (col == 0) begin nt = 0; m_run = 1; end
        end else if (col == m_trk) begin
            m_run = (m_run < TMAX) ? m_run + 1 : TMAX;
        end else if (col == (m_trk + 1) % 3) begin
            m_dur[m_trk] = m_run;
            if (m_trk == 2) m_cyc = (m_cyc + 1) % (QMAX + 1);
            nt = col; m_run = 1;
        end else begin
            m_err = 1; nt = col; m_run = 1;
        end
        if (car && !dep) begin
            if (m_q == QMAX) m_ovf = 1;
            else m_q++;
        end else if (dep && !car) begin
            m_q--;
        end
        if (nt == 2 && m_trk != 2) m_walk = 0;
        else if ((m_trk == 0 || m_trk == 1) && ped) m_walk = 1;
        if (nt == 1 && m_trk != 1) m_ycnt = 0;
        else if (m_trk == 1) m_ycnt++;
        m_trk = nt;
    endtask

    task automatic compare_all();
        chk("queueLen",      32'(queueLen),      32'(m_q));
        chk("walkButton",    32'(walkButton),    32'(m_walk));
        chk("greenTime",     32'(greenTime),     32'(m_dur[0]));
        chk("yellowTime",    32'(yellowTime),    32'(m_dur[1]));
        chk("redTime",       32'(redTime),       32'(m_dur[2]));
        chk("cycleCount",    32'(cycleCount),    32'(m_cyc));
        chk("seqError",      32'(seqError),      32'(m_err));
        chk("queueOverflow", 32'(queueOverflow), 32'(m_ovf));
    endtask

    task automatic step(input logic [1:0] l, input bit car, input bit ped);
        light = l; carArrive = car; pedPress = ped;
        @(posedge clock);
        model_step(l, car, ped);
        #1;
        compare_all();
    endtask

    task automatic steps(input int n, input logic [1:0] l, input bit car);
        for (int i = 0; i < n; i++) step(l, car, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clock);
        model_reset();
        #1;
        compare_all();
        reset = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_q"},    32'(queueLen),   0);
        chk({tag, "_walk"}, 32'(walkButton), 0);
        chk({tag, "_g"},    32'(greenTime),  0);
        chk({tag, "_y"},    32'(yellowTime), 0);
        chk({tag, "_r"},    32'(redTime),    0);
        chk({tag, "_cyc"},  32'(cycleCount), 0);
        chk({tag, "_err"},  32'(seqError),   0);
        chk({tag, "_ovf"},  32'(queueOverflow), 0);
    endtask

    logic [1:0] seq [3];
    logic [1:0] code;
    int         len;

    initial begin
        total = 0; bad = 0;
        reset = 1'b0; light = 2'b00; carArrive = 1'b0; pedPress = 1'b0;
        seq[0] = 2'b10; seq[1] = 2'b01; seq[2] = 2'b00;
        model_reset();
        do_reset();
        chk_all_zero("rst");

        // nominal cycle
        steps(5, 2'b10, 1'b0);
        steps(4, 2'b01, 1'b0);
        steps(6, 2'b00, 1'b0);
        step(2'b10, 1'b0, 1'b0);
        chk("nom_green",  32'(greenTime),  5);
        chk("nom_yellow", 32'(yellowTime), 4);
        chk("nom_red",    32'(redTime),    6);
        chk("nom_cycles", 32'(cycleCount), 1);
        chk("nom_err",    32'(seqError),   0);

        // illegal transition green -> red lands in RED
        steps(2, 2'b10, 1'b0);
        step(2'b00, 1'b0, 1'b0);
        chk("ill_err",   32'(seqError),  1);
        chk("ill_green", 32'(greenTime), 5);
        step(2'b10, 1'b0, 1'b0);
        chk("ill_resync_cyc", 32'(cycleCount), 2);

        // illegal code in INIT
        do_reset();
        step(2'b11, 1'b0, 1'b0);
        chk("init11_err", 32'(seqError), 1);
        step(2'b00, 1'b0, 1'b0);
        step(2'b10, 1'b0, 1'b0);
        step(2'b01, 1'b0, 1'b0);
        chk("init11_green", 32'(greenTime), 1);

        // walk request
        do_reset();
        steps(2, 2'b10, 1'b0);
        step(2'b10, 1'b0, 1'b1);
        chk("walk_set", 32'(walkButton), 1);
        steps(3, 2'b01, 1'b0);
        chk("walk_hold_y", 32'(walkButton), 1);
        step(2'b00, 1'b0, 1'b1);
        chk("walk_clr_red", 32'(walkButton), 0);
        step(2'b00, 1'b0, 1'b1);
        step(2'b00, 1'b0, 1'b0);
        chk("walk_red_ignored", 32'(walkButton), 0);

        // queue with alternating yellow departures
        do_reset();
        step(2'b10, 1'b0, 1'b0);
        step(2'b01, 1'b0, 1'b0);
        step(2'b00, 1'b0, 1'b0);
        steps(10, 2'b00, 1'b1);
        chk("q_fill", 32'(queueLen), 10);
        steps(3, 2'b10, 1'b0);
        step(2'b01, 1'b0, 1'b0);
        chk("q_green3", 32'(queueLen), 7);
        steps(3, 2'b01, 1'b0);
        step(2'b00, 1'b0, 1'b0);
        chk("q_yellow4", 32'(queueLen), 5);

        // queue saturation
        steps(520, 2'b00, 1'b1);
        chk("sat_q",   32'(queueLen),      QMAX);
        chk("sat_ovf", 32'(queueOverflow), 1);
        steps(2, 2'b10, 1'b1);
        chk("sat_green_q", 32'(queueLen), QMAX);

        // reset mid-phase
        do_reset();
        step(2'b10, 1'b0, 1'b0);
        step(2'b01, 1'b0, 1'b0);
        steps(4, 2'b00, 1'b1);
        steps(3, 2'b10, 1'b0);
        do_reset();
        chk_all_zero("midrst");
        steps(4, 2'b10, 1'b0);
        step(2'b01, 1'b0, 1'b0);
        chk("midrst_green", 32'(greenTime), 4);

        // phase counter saturation
        do_reset();
        steps(TMAX + 50, 2'b10, 1'b0);
        step(2'b01, 1'b0, 1'b0);
        chk("tsat_green", 32'(greenTime), TMAX);

        // randomized phases with occasional corrupt codes
        do_reset();
        for (int ph = 0; ph < 80; ph++) begin
            len = int'($urandom_range(1, 9));
            for (int k = 0; k < len; k++) begin
                code = seq[ph % 3];
                if ($urandom_range(0, 39) == 0) code = 2'($urandom_range(0, 3));
                step(code, ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
